// File: rtl/fir_sequencer_if.sv
// Register-bank, memory and result-write signals shared by the FIR sequencer and its environment.
// The master modport is the sequencer side; the slave modport is the register bank plus memories.
interface fir_sequencer_if #(
  parameter int DW   = 16,
  parameter int AW_S = 14,
  parameter int AW_C = 6
);
  logic                   Start;
  logic [AW_C-1:0]        Ile_wsp;
  logic [AW_S-1:0]        Ile_probek;
  logic                   Pracuje;
  logic                   DONE;
  logic [AW_S-1:0]        Adr_probki;
  logic signed [DW-1:0]   Probka_in;
  logic [AW_C-1:0]        Adr_wsp;
  logic signed [DW-1:0]   Wsp_in;
  logic signed [DW-1:0]   Wynik;
  logic [AW_S-1:0]        Adr_wyniku;
  logic                   wr_Wynik;

  modport master (
    input  Start, Ile_wsp, Ile_probek, Probka_in, Wsp_in,
    output Pracuje, DONE, Adr_probki, Adr_wsp, Wynik, Adr_wyniku, wr_Wynik
  );

  modport slave (
    output Start, Ile_wsp, Ile_probek, Probka_in, Wsp_in,
    input  Pracuje, DONE, Adr_probki, Adr_wsp, Wynik, Adr_wyniku, wr_Wynik
  );
endinterface

// File: rtl/fir_sequencer.sv
// Direct-form FIR engine: one MAC per cycle over sample/coef memories, saturated Q15 results.
// States: IDLE wait for Start edge | MAC issue tap reads | FLUSH add last product | WRITE emit y[n] | FIN set DONE
module fir_sequencer #(
  parameter int DW    = 16,
  parameter int AW_S  = 14,
  parameter int AW_C  = 6,
  parameter int ACC_W = 40
) (
  input  logic              clk_b,
  input  logic              rst_n,
  fir_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_FLUSH,
    S_WRITE,
    S_FIN
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DW-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2**(DW-1)));

  state_t                    state_q;
  logic                      start_q;
  logic [AW_C-1:0]           n_taps_q;
  logic [AW_S-1:0]           n_samp_q;
  logic [AW_S-1:0]           n_q;
  logic [AW_C-1:0]           k_q;
  logic                      tap_valid_q;
  logic                      mask_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      wr_q;
  logic signed [DW-1:0]      wynik_q;
  logic [AW_S-1:0]           adr_wyniku_q;
  logic [AW_S-1:0]           adr_probki_q;
  logic [AW_C-1:0]           adr_wsp_q;

  logic [AW_C-1:0]           k_next;
  logic signed [2*DW-1:0]    prod;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [ACC_W-1:0]   acc_shr;
  logic signed [DW-1:0]      sat;

  assign k_next = k_q + AW_C'(1);

  // Memory data lags the address by one cycle, so the product belongs to the tap issued last cycle.
  always_comb begin
    prod    = (2*DW)'(bus.Probka_in) * (2*DW)'(bus.Wsp_in);
    acc_d   = acc_q;
    if (tap_valid_q && !mask_q) begin
      acc_d = acc_q + ACC_W'(prod);
    end
    acc_shr = acc_d >>> (DW - 1);
    if (acc_shr > SAT_MAX) begin
      sat = SAT_MAX[DW-1:0];
    end else if (acc_shr < SAT_MIN) begin
      sat = SAT_MIN[DW-1:0];
    end else begin
      sat = acc_shr[DW-1:0];
    end
  end

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      n_taps_q     <= '0;
      n_samp_q     <= '0;
      n_q          <= '0;
      k_q          <= '0;
      tap_valid_q  <= 1'b0;
      mask_q       <= 1'b0;
      acc_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_q         <= 1'b0;
      wynik_q      <= '0;
      adr_wyniku_q <= '0;
      adr_probki_q <= '0;
      adr_wsp_q    <= '0;
    end else begin
      start_q     <= bus.Start;
      wr_q        <= 1'b0;
      tap_valid_q <= 1'b0;
      mask_q      <= 1'b0;
      acc_q       <= acc_d;
      case (state_q)
        S_IDLE: begin
          if (bus.Start && !start_q) begin
            n_taps_q     <= bus.Ile_wsp;
            n_samp_q     <= bus.Ile_probek;
            done_q       <= 1'b0;
            n_q          <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            adr_wsp_q    <= '0;
            adr_probki_q <= '0;
            if (bus.Ile_wsp == '0 || bus.Ile_probek == '0) begin
              state_q <= S_FIN;
            end else begin
              state_q <= S_MAC;
              busy_q  <= 1'b1;
            end
          end
        end
        S_MAC: begin
          tap_valid_q <= 1'b1;
          mask_q      <= AW_S'(k_q) > n_q;
          k_q         <= k_next;
          if (k_q == n_taps_q - AW_C'(1)) begin
            state_q <= S_FLUSH;
          end else begin
            adr_wsp_q    <= k_next;
            adr_probki_q <= n_q - AW_S'(k_next);
          end
        end
        S_FLUSH: begin
          state_q      <= S_WRITE;
          wr_q         <= 1'b1;
          wynik_q      <= sat;
          adr_wyniku_q <= n_q;
        end
        S_WRITE: begin
          acc_q <= '0;
          k_q   <= '0;
          if (n_q == n_samp_q - AW_S'(1)) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            n_q          <= n_q + AW_S'(1);
            state_q      <= S_MAC;
            adr_wsp_q    <= '0;
            adr_probki_q <= n_q + AW_S'(1);
          end
        end
        S_FIN: begin
          // Already set when arriving from WRITE; the empty-job path sets it here.
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Pracuje    = busy_q;
  assign bus.DONE       = done_q;
  assign bus.wr_Wynik   = wr_q;
  assign bus.Wynik      = wynik_q;
  assign bus.Adr_wyniku = adr_wyniku_q;
  assign bus.Adr_probki = adr_probki_q;
  assign bus.Adr_wsp    = adr_wsp_q;

endmodule

// File: doc/fir_sequencer.md
# fir_sequencer

FIR processing engine that sits directly downstream of the control register bank. It consumes the Start, Ile_wsp and Ile_probek register outputs and returns the Pracuje and DONE status bits. On a Start rising edge it runs a direct-form FIR over sample memory against coefficient memory, one MAC per cycle, and writes saturated Q15 results to result memory.

## Interface
- DW, 16, sample, coefficient and result width (signed, Q15)
- AW_S, 14, sample/result address width (matches Ile_probek)
- AW_C, 6, coefficient address width (matches Ile_wsp)
- ACC_W, 40, accumulator width (signed)
- clk_b  in  1  system clock; one clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Start  in  1  run request level from the register bank; only a rising edge acts
- Ile_wsp  in  AW_C  number of taps N; latched at run start
- Ile_probek  in  AW_S  number of samples M; latched at run start
- Pracuje  out  1  busy flag
- DONE  out  1  run-complete flag, sticky
- Adr_probki  out  AW_S  sample memory read address
- Probka_in  in  DW  sample memory read data; synchronous read, valid 1 cycle after the address
- Adr_wsp  out  AW_C  coefficient memory read address
- Wsp_in  in  DW  coefficient memory read data; same 1-cycle latency
- Wynik  out  DW  result data
- Adr_wyniku  out  AW_S  result address
- wr_Wynik  out  1  result write strobe, 1 cycle per result

## Operation
- Computes y[n] = sat16((sum over k=0..N-1 of h[k]*x[n-k]) >>> 15) for n = 0..M-1. Any x with a negative index contributes 0.
- Start edge detect: register start_q. A trigger occurs when Start=1 and start_q=0 while in IDLE. Start edges in any other state are ignored, and a held-high Start never retriggers.
- FSM states:
  - IDLE: waits for a trigger. On trigger, latches N and M, clears DONE, sets n=0, k=0 and acc=0. If N=0 or M=0, goes to FIN. Otherwise goes to MAC.
  - MAC: drives Adr_wsp=k and Adr_probki=n-k (mod 2^AW_S). Registers tap_valid=1 and mask=(k>n) for the next cycle. k increments each cycle. After k=N-1, goes to FLUSH.
  - FLUSH: no new address. Accumulates the final product, then goes to WRITE.
  - WRITE: Wynik=sat16(acc>>>15), Adr_wyniku=n, wr_Wynik=1, then acc=0 and k=0.
    - If n=M-1, goes to FIN.
    - Otherwise n increments and the FSM goes back to MAC.
  - FIN: sets DONE=1, clears Pracuje, goes to IDLE.
- Accumulate rule: in any cycle where the delayed tap_valid is 1, acc += (mask ? 0 : sext(Probka_in)*sext(Wsp_in)). The product is 32-bit signed and sign-extended to ACC_W.
- Shift is arithmetic (floor toward minus infinity). Saturation clamps to [-32768, 32767].
- Pracuje=1 in MAC, FLUSH and WRITE; 0 otherwise.
- DONE stays 1 until the next accepted trigger or reset.
- Ile_wsp and Ile_probek changing mid-run have no effect; the latched copies are used.

## Timing
- Reset values: Pracuje=0, DONE=0, wr_Wynik=0, Wynik=0, Adr_wyniku=0, Adr_probki=0, Adr_wsp=0. Internal state: IDLE, acc=0, start_q=0.
- Pracuje rises on the same clock edge that samples the trigger.
- Each sample takes N+2 cycles (N MAC, 1 FLUSH, 1 WRITE). Pracuje is high for exactly M*(N+2) cycles.
- wr_Wynik pulses in the last cycle of each sample window. Consecutive pulses are N+2 cycles apart.
- DONE rises on the edge after the last WRITE cycle, i.e. the same edge that drops Pracuje.
- With N=0 or M=0: the trigger edge moves the FSM to FIN, Pracuje never rises, DONE rises 1 cycle later, and there is no wr_Wynik.
- Asserting rst_n low mid-run forces all reset values immediately. No further writes occur, and DONE stays 0.
- Write outputs (Wynik, Adr_wyniku) are registered and valid only while wr_Wynik=1.

## Test plan
- Reset, then idle 10 cycles with Start=0 -> all outputs 0 and no wr_Wynik.
- N=1, h=[0x4000], M=4, x=[100,200,-300,1000], Start 0->1 -> writes (0,50),(1,100),(2,-150),(3,500) spaced 3 cycles apart. Pracuje is high 12 cycles, then DONE=1 and stays 1.
- N=3, h=[1000,2000,3000], M=5, x=[32767,0,0,0,0] -> Wynik=[999,1999,2999,0,0]. Wynik[0]=999 checks zero-masking for k>n.
- Saturation: N=2, h=[0x7FFF,0x7FFF].
  - x=[32767,32767] -> [32766,32767].
  - x=[-32768,-32768] -> [-32767,-32768].
- M=0 with N=5, then N=0 with M=5 -> in both cases no wr_Wynik, Pracuje stays 0, DONE=1 one cycle after the trigger.
- Start held high through a run with a second 0->1 pulse mid-run -> exactly one run (M writes).
- Reset asserted during sample 2 -> outputs return to reset values, no further writes. A new Start edge then runs a full job from n=0.
